fp_add_scheduler: RTL
=====================

Name: fp_add_scheduler

Overview:
Shares one multi-cycle single-precision FP adder between NUM_REQ requesters. The adder has no handshake, so this block sequences it. It arbitrates round-robin, latches and holds the operands for a fixed settle time, and captures the sum. It returns the sum to the winning requester with its ID. Operands with a zero exponent field bypass the adder, because the adder assumes a hidden 1 bit.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADD_LATENCY, 32, cycles operands must be held stable before the adder Sum is valid (min 2)
ID_W, 2, width of resp_id; must be at least clog2(NUM_REQ)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held high until accepted
req_op1  in  NUM_REQ*32  packed operand 1, slice i = requester i
req_op2  in  NUM_REQ*32  packed operand 2
req_ready  out  NUM_REQ  one-hot acceptance strobe
add_op1  out  32  operand 1 to adder
add_op2  out  32  operand 2 to adder
add_sum  in  32  adder result
busy  out  1  high whenever state is not IDLE
resp_valid  out  1  one-cycle result strobe
resp_id  out  ID_W  index of the requester that owns the result
resp_sum  out  32  result word

Behaviour:
- Reset, synchronous, on rst_n=0 at a clock edge:
  - State goes to IDLE and the counter clears.
  - Operand regs, result reg, resp_valid, resp_id and resp_sum all go to 0.
  - The round-robin pointer goes to NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation abandons the operation; no response is emitted.
- States: IDLE, HOLD, DONE.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching upward from rr_ptr+1, with wrap.
  - req_ready[winner]=1 combinationally in that cycle; all other bits are 0.
  - The winner's operands and ID are latched, and rr_ptr becomes the winner.
- Zero bypass, decided at accept:
  - If op1[30:23]==0, the result is op2, the adder is skipped, and the next state is DONE.
  - Else if op2[30:23]==0, the result is op1 and the next state is DONE.
  - If both exponents are 0, the result is op2.
  - Otherwise the counter is set to 0 and the next state is HOLD.
- HOLD:
  - add_op1/add_op2 are driven from the latched regs and stay constant for the whole state.
  - The counter increments each cycle.
  - When count==ADD_LATENCY-1, add_sum is captured into the result reg and the next state is DONE.
  - HOLD therefore lasts exactly ADD_LATENCY cycles.
- DONE:
  - resp_valid=1 for exactly one cycle, with resp_id and resp_sum valid; the next state is IDLE.
  - There is no response backpressure; the requester must sample it.
- add_op1/add_op2 outside HOLD: they keep their last latched values and never glitch to requester inputs.
- Latency, with acceptance at cycle T:
  - Normal path: resp_valid at T+ADD_LATENCY+1.
  - Bypass path: resp_valid at T+1.
- Throughput:
  - req_ready is never asserted outside IDLE.
  - Back-to-back accepts are separated by ADD_LATENCY+2 cycles (bypass: 2).
- resp_valid, resp_id, resp_sum: registered outputs. resp_id and resp_sum hold their values after the strobe until the next DONE.
- Simultaneous requests: only one is granted per IDLE cycle; losers keep req_valid high.
- A requester dropping req_valid before its grant: legal, and it is simply not granted.
- rr_ptr update: changes only on an accept.
- Sign handling: signs are not checked. The adder implements magnitude add using op1's sign, and the scheduler passes this through unchanged.

Decomposition:
- Package fp_add_pkg:
  - FP_W=32, EXP_MSB=30, EXP_LSB=23.
  - State enum {IDLE, HOLD, DONE}.
  - A function is_zero_exp(word).
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
- The scheduler holds the FSM, counter, operand/result regs and bypass logic.

Test Plan:
- Single request: req0 with op1=0x3F800000 and op2=0x3F800000, behavioural adder of latency 32 -> req_ready[0] at T; add_op stable 32 cycles; resp_valid at T+33 with id=0 and sum=0x40000000.
- Round robin: all four requesters valid continuously after reset -> grants in order 0,1,2,3,0 at spacing 34 cycles; resp_id sequence matches the grants.
- Zero bypass: req2 with op1=0x00000000 and op2=0x40400000 -> resp_valid at T+1 with id=2 and sum=0x40400000; the adder operands are not updated.
- Mixed traffic: req1 sends 0x3F800000+0x40000000 (result 0x40400000) while req3 waits -> req3 is granted in the IDLE cycle after req1's DONE; req_ready is never high during HOLD.
- Reset mid-HOLD: rst_n low at cycle T+10 of a normal operation -> no resp_valid; all outputs 0; next grant goes to req0 even if rr_ptr was 2.
- Parameter check: ADD_LATENCY=2, with 0x3FC00000+0x3FC00000 -> resp at T+3 with sum=0x40400000.

Source files
------------

// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared constants, FSM state type and exponent helper for the FP add scheduler
package fp_add_pkg;
   localparam int FP_W = 32;
   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;
   typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
   function automatic logic is_zero_exp(input logic [FP_W-1:0] word);
      return word[EXP_MSB:EXP_LSB] == '0;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request above ptr with wrap
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx
);
   logic hit;
   // lowest request at or below ptr, then overridden by the lowest request above ptr
   always_comb begin
      grant_idx = '0;
      hit = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req[i] && i <= int'(ptr)) begin
            grant_idx = IW'(i);
            hit = 1'b1;
         end
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req[i] && i > int'(ptr)) begin
            grant_idx = IW'(i);
            hit = 1'b1;
         end
      grant = (enable && hit) ? NUM_REQ'(1) << grant_idx : '0;
   end
endmodule

// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: shares one fixed-latency FP adder between requesters with zero-exponent bypass
module fp_add_scheduler
   import fp_add_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADD_LATENCY = 32,
   parameter int ID_W = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*FP_W-1:0] req_op1,
   input  logic [NUM_REQ*FP_W-1:0] req_op2,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [FP_W-1:0]         add_op1,
   output logic [FP_W-1:0]         add_op2,
   input  logic [FP_W-1:0]         add_sum,
   output logic                    busy,
   output logic                    resp_valid,
   output logic [ID_W-1:0]         resp_id,
   output logic [FP_W-1:0]         resp_sum
);
   localparam int CW = $clog2(ADD_LATENCY);
   localparam logic [CW-1:0] LAST = CW'(ADD_LATENCY - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic [ID_W-1:0] rr_ptr, id_q, grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic [FP_W-1:0] op1_q, op2_q, sel_op1, sel_op2;
   logic byp1, byp2;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(ID_W)) u_arb (
      .req(req_valid),
      .ptr(rr_ptr),
      .enable(state == IDLE),
      .grant(grant),
      .grant_idx(grant_idx)
   );

   assign req_ready = grant;
   assign busy = state != IDLE;
   assign add_op1 = op1_q;
   assign add_op2 = op2_q;
   assign byp1 = is_zero_exp(sel_op1);
   assign byp2 = is_zero_exp(sel_op2);

   // operands of the granted requester
   always_comb begin
      sel_op1 = '0;
      sel_op2 = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) begin
            sel_op1 = req_op1[i*FP_W +: FP_W];
            sel_op2 = req_op2[i*FP_W +: FP_W];
         end
   end

   // sequencer: accept, hold operands for the adder settle time, strobe the result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         op1_q <= '0;
         op2_q <= '0;
         id_q <= '0;
         rr_ptr <= ID_W'(NUM_REQ - 1);
         resp_valid <= 1'b0;
         resp_id <= '0;
         resp_sum <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: if (|grant) begin
               rr_ptr <= grant_idx;
               id_q <= grant_idx;
               if (byp1 || byp2) begin
                  state <= DONE;
                  resp_valid <= 1'b1;
                  resp_id <= grant_idx;
                  resp_sum <= byp1 ? sel_op2 : sel_op1;
               end else begin
                  state <= HOLD;
                  cnt <= '0;
                  op1_q <= sel_op1;
                  op2_q <= sel_op2;
               end
            end
            HOLD: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
                  resp_valid <= 1'b1;
                  resp_id <= id_q;
                  resp_sum <= add_sum;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
